// File: rtl/md5_guess_engine_if.sv
// md5_guess_engine_if: candidate/digest handshake between the guess engine and an MD5 core.
//   master (engine): drives guess, guess_width, guess_valid; receives hasher_ready, hash_in, hash_in_valid
//   slave  (MD5 core): the mirror image
interface md5_guess_engine_if;
  logic [127:0] guess;
  logic [7:0]   guess_width;
  logic         guess_valid;
  logic         hasher_ready;
  logic [127:0] hash_in;
  logic         hash_in_valid;

  modport master (
    output guess, guess_width, guess_valid,
    input  hasher_ready, hash_in, hash_in_valid
  );

  modport slave (
    input  guess, guess_width, guess_valid,
    output hasher_ready, hash_in, hash_in_valid
  );
endinterface

// File: rtl/md5_guess_engine.sv
// md5_guess_engine: brute-force plaintext enumerator, digest comparator and run controller.
// Enumerates right-aligned candidates of 1..8 characters, offers each to an MD5 core once,
// compares the returned digest with target_hash and latches the matching plaintext.
// Optional build macro MD5_GUESS_DIGITS_EN: extends the character set with '0'..'9' (N=36);
// without it the set is 'a'..'z' (N=26).
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   starting_position [7:0] start index of the rightmost character (mod N)
//   increment [2:0]         stride of the rightmost character (0 acts as 1)
//   target_hash [127:0]     digest to match, stable while enable=1
//   hasher (master)         guess/guess_width/guess_valid out, hasher_ready/hash_in/hash_in_valid in
//   enable                  search running
//   hashes_equal            match found (sticky)
//   exhausted               search space ended without a match (sticky)
//   plaintext [127:0]       matching candidate, same layout as guess
module md5_guess_engine (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          starting_position,
  input  logic [2:0]          increment,
  input  logic [127:0]        target_hash,
  md5_guess_engine_if.master  hasher,
  output logic                enable,
  output logic                hashes_equal,
  output logic                exhausted,
  output logic [127:0]        plaintext
);

`ifdef MD5_GUESS_DIGITS_EN
  localparam int unsigned N = 36;
`else
  localparam int unsigned N = 26;
`endif
  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned DIGIT_W = 6;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned SUM_W   = 7;

  typedef logic [MAX_LEN-1:0][DIGIT_W-1:0] digits_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMPARE,
    S_DONE,
    S_EXHAUSTED
  } state_t;

  state_t           state;
  digits_t          digits;
  logic [LEN_W-1:0] len;
  logic [127:0]     digest;

  logic [2:0]         stride_c;
  logic [DIGIT_W-1:0] start_digit_c;
  digits_t            next_digits_c;
  logic [LEN_W-1:0]   next_len_c;
  logic               overflow_c;

  // Digit value to character: 0..25 -> 'a'..'z', 26..35 -> '0'..'9'.
  function automatic logic [7:0] to_char(input logic [DIGIT_W-1:0] v);
    if (v < DIGIT_W'(26)) return 8'h61 + 8'(v);
    else                  return 8'h30 + 8'(v - DIGIT_W'(26));
  endfunction

  // Right-aligned byte image of a candidate; bytes at and above len are zero.
  function automatic logic [127:0] render(input digits_t d, input logic [LEN_W-1:0] l);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (LEN_W'(i) < l) r[i*8 +: 8] = to_char(d[i]);
    end
    return r;
  endfunction

  assign stride_c      = (increment == 3'd0) ? 3'd1 : increment;
  assign start_digit_c = DIGIT_W'(starting_position % 8'(N));

  // Advance: stride into d0, single carries ripple upward; a carry past the top
  // digit grows the candidate by one character of value 0, or overflows at length 8.
  always_comb begin
    logic             carry;
    logic [SUM_W-1:0] sum;
    carry         = 1'b0;
    sum           = '0;
    next_digits_c = digits;
    next_len_c    = len;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if (LEN_W'(i) < len) begin
        if (i == 0) sum = SUM_W'(digits[i]) + SUM_W'(stride_c);
        else        sum = SUM_W'(digits[i]) + SUM_W'(carry);
        if (sum >= SUM_W'(N)) begin
          next_digits_c[i] = DIGIT_W'(sum - SUM_W'(N));
          carry            = 1'b1;
        end else begin
          next_digits_c[i] = DIGIT_W'(sum);
          carry            = 1'b0;
        end
      end else if ((LEN_W'(i) == len) && carry) begin
        next_digits_c[i] = '0;
        next_len_c       = len + LEN_W'(1);
        carry            = 1'b0;
      end
    end
    overflow_c = carry;
  end

  // Run controller; guess only changes on load or advance, so each candidate is requested once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      digits             <= '0;
      len                <= '0;
      digest             <= '0;
      hasher.guess       <= '0;
      hasher.guess_width <= '0;
      hasher.guess_valid <= 1'b0;
      enable             <= 1'b0;
      hashes_equal       <= 1'b0;
      exhausted          <= 1'b0;
      plaintext          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          digits             <= digits_t'(start_digit_c);
          len                <= LEN_W'(1);
          hasher.guess       <= render(digits_t'(start_digit_c), LEN_W'(1));
          hasher.guess_width <= 8'd8;
          hasher.guess_valid <= 1'b1;
          enable             <= 1'b1;
          state              <= S_ISSUE;
        end
        S_ISSUE: begin
          if (hasher.hasher_ready) begin
            hasher.guess_valid <= 1'b0;
            state              <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (hasher.hash_in_valid) begin
            digest <= hasher.hash_in;
            state  <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (digest == target_hash) begin
            plaintext    <= hasher.guess;
            hashes_equal <= 1'b1;
            enable       <= 1'b0;
            state        <= S_DONE;
          end else if (overflow_c) begin
            exhausted <= 1'b1;
            enable    <= 1'b0;
            state     <= S_EXHAUSTED;
          end else begin
            digits             <= next_digits_c;
            len                <= next_len_c;
            hasher.guess       <= render(next_digits_c, next_len_c);
            hasher.guess_width <= 8'({next_len_c, 3'b000});
            hasher.guess_valid <= 1'b1;
            state              <= S_ISSUE;
          end
        end
        S_DONE:      state <= S_DONE;
        S_EXHAUSTED: state <= S_EXHAUSTED;
        default:     state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_guess_engine.sv
// tb_md5_guess_engine: randomized bench for md5_guess_engine. A behavioural MD5 stand-in
// answers each request with a keyed digest of the candidate; the reference treats the
// candidate as an L-digit base-N number advanced by plain arithmetic.
module tb_md5_guess_engine;

`ifdef MD5_GUESS_DIGITS_EN
  localparam int N = 36;
`else
  localparam int N = 26;
`endif
  localparam logic [127:0] SALT = 128'h5a3c_96e1_0f27_d4b8_c3a1_7e65_2b90_4df1;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   starting_position;
  logic [2:0]   increment;
  logic [127:0] target_hash;
  logic         enable;
  logic         hashes_equal;
  logic         exhausted;
  logic [127:0] plaintext;

  md5_guess_engine_if hif ();

  md5_guess_engine dut (
    .clock             (clock),
    .reset             (reset),
    .starting_position (starting_position),
    .increment         (increment),
    .target_hash       (target_hash),
    .hasher            (hif),
    .enable            (enable),
    .hashes_equal      (hashes_equal),
    .exhausted         (exhausted),
    .plaintext         (plaintext)
  );

  always #5 clock = ~clock;

  int checks;
  int errors;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_val;
  int     m_len;
  int     m_stride;

  function automatic longint pow_n(input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * N;
    return r;
  endfunction

  function automatic logic [127:0] render(input longint v, input int len);
    logic [127:0] r = '0;
    longint d;
    for (int i = 0; i < len; i++) begin
      d = (v / pow_n(i)) % N;
      r[i*8 +: 8] = (d < 26) ? 8'(64'h61 + d) : 8'(64'h30 + d - 26);
    end
    return r;
  endfunction

  function automatic logic [127:0] fake_digest(input logic [127:0] g);
    return {g[63:0], g[127:64]} ^ SALT;
  endfunction

  task automatic model_start(input int start, input int inc);
    m_val    = longint'(start % N);
    m_len    = 1;
    m_stride = (inc == 0) ? 1 : inc;
  endtask

  function automatic bit model_advance();
    m_val = m_val + m_stride;
    if (m_val >= pow_n(m_len)) begin
      if (m_len == 8) return 1'b1;
      m_val = m_val - pow_n(m_len);
      m_len++;
    end
    return 1'b0;
  endfunction

  function automatic logic [127:0] candidate_at(input int start, input int inc, input int k);
    longint v = longint'(start % N);
    int len = 1;
    int s = (inc == 0) ? 1 : inc;
    for (int i = 0; i < k; i++) begin
      v = v + s;
      if (v >= pow_n(len)) begin
        v = v - pow_n(len);
        len++;
      end
    end
    return render(v, len);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic check_zero(input string pfx);
    check({pfx, "_enable"}, 128'(enable), 128'(0));
    check({pfx, "_gv"},     128'(hif.guess_valid), 128'(0));
    check({pfx, "_equal"},  128'(hashes_equal), 128'(0));
    check({pfx, "_exh"},    128'(exhausted), 128'(0));
    check({pfx, "_guess"},  hif.guess, 128'(0));
    check({pfx, "_width"},  128'(hif.guess_width), 128'(0));
    check({pfx, "_plain"},  plaintext, 128'(0));
  endtask

  task automatic do_reset(input int start, input int inc, input logic [127:0] tgt);
    @(negedge clock);
    reset             = 1'b1;
    starting_position = 8'(start);
    increment         = 3'(inc);
    target_hash       = tgt;
    hif.hasher_ready  = 1'b0;
    hif.hash_in_valid = 1'b0;
    hif.hash_in       = '0;
    repeat (2) @(negedge clock);
    check_zero("rst");
    reset = 1'b0;
    model_start(start, inc);
    @(negedge clock);
    check("first_gv", 128'(hif.guess_valid), 128'(1));
  endtask

  // One full request/response; stall = cycles hasher_ready is held low.
  task automatic serve(input int stall, input bit stray, output bit matched, output bit stop);
    int b = 0;
    logic [127:0] g;
    bit ovf;
    matched = 1'b0;
    stop    = 1'b0;
    while (hif.guess_valid !== 1'b1 && b < 20) begin
      @(negedge clock);
      b++;
    end
    check("gv_wait", 128'(hif.guess_valid), 128'(1));
    if (hif.guess_valid !== 1'b1) begin
      stop = 1'b1;
      return;
    end
    g = render(m_val, m_len);
    check("guess", hif.guess, g);
    check("width", 128'(hif.guess_width), 128'(8 * m_len));
    for (int k = 0; k < stall; k++) begin
      if (stray && k == stall / 2) begin
        hif.hash_in       = target_hash;
        hif.hash_in_valid = 1'b1;
      end
      @(negedge clock);
      hif.hash_in_valid = 1'b0;
      check("stall_gv", 128'(hif.guess_valid), 128'(1));
      check("stall_guess", hif.guess, g);
    end
    hif.hasher_ready = 1'b1;
    @(negedge clock);
    hif.hasher_ready = 1'b0;
    check("accept_gv", 128'(hif.guess_valid), 128'(0));
    repeat ($urandom_range(0, 2)) @(negedge clock);
    hif.hash_in       = fake_digest(g);
    hif.hash_in_valid = 1'b1;
    @(negedge clock);
    hif.hash_in_valid = 1'b0;
    @(negedge clock);
    matched = (fake_digest(g) == target_hash);
    if (matched) begin
      check("hit_equal", 128'(hashes_equal), 128'(1));
      check("hit_enable", 128'(enable), 128'(0));
      check("hit_plain", plaintext, g);
      check("hit_gv", 128'(hif.guess_valid), 128'(0));
      stop = 1'b1;
    end else begin
      ovf = model_advance();
      check("next_gv", 128'(hif.guess_valid), 128'(!ovf));
      check("miss_enable", 128'(enable), 128'(!ovf));
      check("miss_equal", 128'(hashes_equal), 128'(0));
      check("miss_exh", 128'(exhausted), 128'(ovf));
      if (ovf) stop = 1'b1;
    end
  endtask

  task automatic run(input int n, input int max_stall, output int hit_idx);
    bit m, s;
    hit_idx = -1;
    for (int i = 0; i < n; i++) begin
      serve($urandom_range(0, max_stall), 1'b0, m, s);
      if (m) hit_idx = i;
      if (s) break;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    bit m, s, seen;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    starting_position = '0;
    increment = '0;
    target_hash = SALT;
    hif.hasher_ready = 1'b0;
    hif.hash_in_valid = 1'b0;
    hif.hash_in = '0;

    // Plain sequence through 'z' -> 'aa' -> 'ab'
    do_reset(0, 1, SALT);
    run(N + 4, 0, h);
    check("seq_nohit", 128'(h), 128'(-1));

    // Stride 3 from 'c'
    do_reset(2, 3, SALT);
    run(14, 1, h);

    // Increment 0 behaves as 1, start taken modulo N
    do_reset(200, 0, SALT);
    run(15, 2, h);

    // Match on the third candidate
    do_reset(0, 1, fake_digest(candidate_at(0, 1, 2)));
    run(10, 0, h);
    check("match_idx", 128'(h), 128'(2));
    check("match_plain", plaintext, 128'h63);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (hif.guess_valid) seen = 1'b1;
    end
    check("no_reissue", 128'(seen), 128'(0));
    check("equal_sticky", 128'(hashes_equal), 128'(1));

    // Ten-cycle stall with a stray digest pulse outside WAIT
    do_reset(5, 2, SALT);
    serve(10, 1'b1, m, s);
    check("stall_nohit", 128'(m), 128'(0));
    run(3, 0, h);

    // Reset while waiting for the digest
    do_reset(7, 1, SALT);
    run(2, 0, h);
    while (hif.guess_valid !== 1'b1) @(negedge clock);
    hif.hasher_ready = 1'b1;
    @(negedge clock);
    hif.hasher_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_zero("midrst");
    do_reset(77, 1, SALT);
    check("restart_guess", hif.guess, 128'(8'h61 + 8'(77 % N)));
    run(5, 0, h);

    // Last character of the set rolling into the next length
    do_reset(25, 1, SALT);
    run(15, 0, h);

    // Randomized runs, with or without a reachable target
    for (int r = 0; r < 8; r++) begin
      int st, inc, n, k;
      st  = $urandom_range(0, 255);
      inc = $urandom_range(0, 7);
      n   = $urandom_range(5, 40);
      k   = $urandom_range(0, n + 10);
      do_reset(st, inc, (k < n) ? fake_digest(candidate_at(st, inc, k)) : SALT);
      run(n, 2, h);
      check("rand_hit", 128'(h), (k < n) ? 128'(k) : 128'(-1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md5_guess_engine.md
# md5_guess_engine

Brute-force candidate generator, hash comparator and run controller for an MD5 password-recovery pipeline. Enumerates plaintext candidates over a fixed character set, hands each to an external MD5 core via a valid/ready handshake, compares the returned digest against a target hash, and stops with the matching plaintext latched. Multiple instances can partition the search space with different start offsets and strides.

## Interface
- No parameters.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- starting_position  in  8  start index of the last (rightmost) character; sampled on the first clock after reset deasserts; taken modulo N.
- increment  in  3  stride added to the last-character index per candidate; 0 is treated as 1.
- target_hash  in  128  digest to match; must be held stable while enable=1.
- hasher_ready  in  1  MD5 core can accept a word.
- hash_in  in  128  digest from the MD5 core.
- hash_in_valid  in  1  hash_in is valid this cycle.
- guess  out  128  candidate, right-aligned: last character in guess[7:0], unused upper bytes 0.
- guess_width  out  8  candidate length in bits (8 × L).
- guess_valid  out  1  guess/guess_width are offered to the MD5 core.
- enable  out  1  search running.
- hashes_equal  out  1  match found; sticky.
- exhausted  out  1  search space ended without a match; sticky.
- plaintext  out  128  matching candidate, same layout as guess.

## Operation
- Character set: 'a'..'z' (0x61..0x7A), N=26; digit value v maps to 0x61+v.
- Candidate state: length L (1..8) and digits d0..d7, where d0 is the rightmost character. Byte i of guess = char(d_i) for i<L; otherwise 0.
- Start values: L=1, d0=starting_position mod N.
- Advance: d0 += stride; if d0 ≥ N then d0 -= N and carry into d1 (+1), rippling upward. A carry out of digit L-1 sets L=L+1 and the new digit to 0 (e.g. 'z' → 'aa'). A carry out of digit 7 with L=8 is exhaustion.
- FSM states:
  - IDLE: enable=0.
  - ISSUE: guess_valid=1.
  - WAIT: waits for the digest.
  - COMPARE: one-cycle compare.
  - DONE: match found.
  - EXHAUSTED: search space ended.
- Transitions:
  - IDLE→ISSUE: first clock after reset deasserts. Loads the start candidate and sets enable=1.
  - ISSUE→WAIT: on guess_valid && hasher_ready.
  - WAIT→COMPARE: on hash_in_valid. Captures hash_in; hash_in_valid outside WAIT is ignored.
  - COMPARE, captured digest == target_hash → DONE: plaintext←guess, hashes_equal=1, enable=0.
  - COMPARE, no match → ISSUE with the advanced candidate, or → EXHAUSTED (exhausted=1, enable=0) if advancing overflows.
  - DONE and EXHAUSTED are terminal until reset.
- guess is updated only on the advance, so exactly one hash is requested per candidate and no candidate is skipped.

## Timing
- Reset values: enable=0, guess_valid=0, hashes_equal=0, exhausted=0, guess=0, guess_width=0, plaintext=0, state IDLE.
- Reset mid-operation aborts immediately and clears all outputs; the search restarts from starting_position.
- First guess_valid appears 1 cycle after reset deasserts.
- guess and guess_width stay stable while guess_valid=1 and hasher_ready=0.
- Digest capture to result: 1 cycle. hashes_equal/exhausted rise and enable falls on the same edge, the one after the COMPARE cycle.
- The next guess_valid asserts on that same edge after a mismatch. Minimum per-candidate loop with an immediate-responding core: 3 cycles.

## Configuration
- MD5_GUESS_DIGITS_EN defined: character set is 'a'..'z' followed by '0'..'9' (digit 26→0x30 … 35→0x39), N=36.
- MD5_GUESS_DIGITS_EN not defined: N=26, lowercase only.
- All modulo, wrap and carry rules use the configured N.

## Test plan
- Sequence, start=0, inc=1, bench hasher returns non-matching digests: guesses 0x61 (width 8), 0x62, …, 0x7A, then 0x6161 (width 16), then 0x6162.
- Stride, start=2, inc=3: guesses 'c','f',…,'x', then 0x6161 ('aa'), then 0x6164 ('ad').
- Match: target returned on the 3rd candidate (start=0, inc=1) → plaintext=0x63, hashes_equal=1 and enable=0 one cycle after capture; guess_valid never reasserts.
- Stall: hasher_ready held low 10 cycles → guess_valid stays 1 and guess is unchanged; a single request occurs after ready rises.
- Mid-run reset: reset pulsed while in WAIT → all outputs return to 0; first guess after release is char(starting_position mod N).
- Config: with MD5_GUESS_DIGITS_EN, start=25, inc=1 → 'z', '0', …, '9', then 'aa'.
